// File: rtl/snes_pkg.sv
// snes_pkg: button bit positions, frame sizes and reader state encoding.
package snes_pkg;
   localparam int SNES_BITS = 16;
   localparam int SNES_BTNS = 12;
   localparam int SNES_B = 0;
   localparam int SNES_Y = 1;
   localparam int SNES_SELECT = 2;
   localparam int SNES_START = 3;
   localparam int SNES_UP = 4;
   localparam int SNES_DOWN = 5;
   localparam int SNES_LEFT = 6;
   localparam int SNES_RIGHT = 7;
   localparam int SNES_A = 8;
   localparam int SNES_X = 9;
   localparam int SNES_L = 10;
   localparam int SNES_R = 11;
   typedef enum logic [2:0] {IDLE, LATCH, CLK_LO, CLK_HI, DONE} state_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer; resets to 1 so an unknown line reads as released.
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic m;
   always_ff @(posedge clk or negedge reset)
      if (!reset) {q, m} <= 2'b11;
      else {q, m} <= {m, d};
endmodule

// File: rtl/snes_reader.sv
// snes_reader: polls an SNES pad at a fixed rate and publishes an active-high
// 12-bit button word once per complete 16-bit frame.
module snes_reader import snes_pkg::*; #(
   parameter int TICK_DIV = 300,
   parameter int POLL_DIV = 833333
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 snes_serial_in,
   output logic                 snes_latch,
   output logic                 snes_clock,
   output logic [SNES_BTNS-1:0] snes_data,
   output logic                 snes_valid,
   output logic                 busy
);
   localparam int PW = $clog2(POLL_DIV);
   localparam int TW = $clog2(2 * TICK_DIV);
   state_t state, state_n;
   logic [PW-1:0] poll;
   logic [TW-1:0] tick;
   logic [3:0] idx;
   logic [SNES_BITS-1:0] shift;
   logic din, wrap, tick_end;
   sync2 u_sync (.clk(clk), .reset(reset), .d(snes_serial_in), .q(din));
   assign wrap = poll == PW'(POLL_DIV - 1);
   assign tick_end = tick == TW'((state == LATCH ? 2 * TICK_DIV : TICK_DIV) - 1);
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (wrap) state_n = LATCH;
         LATCH:   if (tick_end) state_n = CLK_LO;
         CLK_LO:  if (tick_end) state_n = CLK_HI;
         CLK_HI:  if (tick_end) state_n = idx == 4'd15 ? DONE : CLK_LO;
         default: state_n = IDLE;
      endcase
      snes_latch = state == LATCH;
      snes_clock = state != CLK_LO;
      busy = state != IDLE;
   end
   // LSB-first right shift: after 16 samples bit i sits at shift[i]
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         poll <= '0;
         tick <= '0;
         idx <= '0;
         shift <= '0;
         snes_data <= '0;
         snes_valid <= 1'b0;
      end else begin
         state <= state_n;
         poll <= wrap ? '0 : poll + 1'b1;
         tick <= (state == IDLE || state_n != state) ? '0 : tick + 1'b1;
         if (state == LATCH) idx <= '0;
         else if (state == CLK_HI && tick_end) idx <= idx + 1'b1;
         if (state == CLK_LO && tick_end) shift <= {din, shift[SNES_BITS-1:1]};
         snes_valid <= state == DONE;
         if (state == DONE) snes_data <= ~shift[SNES_BTNS-1:0];
      end
endmodule

// File: tb/tb_snes_reader.sv
// tb_snes_reader: pad model plus scoreboard of expected button words per frame.
module tb_snes_reader;
   logic clk = 0, reset = 0, serial = 1;
   logic snes_latch, snes_clock, snes_valid, busy;
   logic [11:0] snes_data;
   logic [15:0] pat = 16'hFFFF;
   logic [11:0] sb[$];
   int ptr = 16, cyc = 0, rise_cyc = 0, rel_cyc = 0, falls = 0, nvalid = 0, tests = 0, fails = 0;
   bit have_rise = 0, after_rel = 0;
   logic lat_p = 0, clk_p = 1, val_p = 0;

   snes_reader #(.TICK_DIV(4), .POLL_DIV(200)) dut (
      .clk(clk), .reset(reset), .snes_serial_in(serial), .snes_latch(snes_latch),
      .snes_clock(snes_clock), .snes_data(snes_data), .snes_valid(snes_valid), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge snes_latch) begin
      serial = pat[0];
      ptr = 1;
   end
   always @(posedge snes_clock)
      if (ptr < 16) begin
         serial = pat[ptr];
         ptr++;
      end else serial = 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         falls = 0;
         have_rise = 0;
      end else begin
         if (snes_latch && !lat_p) begin
            if (after_rel) check("first_latch", cyc - rel_cyc, 200);
            else if (have_rise) check("cadence", cyc - rise_cyc, 200);
            after_rel = 0;
            have_rise = 1;
            rise_cyc = cyc;
            falls = 0;
         end
         if (!snes_latch && lat_p) check("latch_width", cyc - rise_cyc, 8);
         if (!snes_clock && clk_p) falls++;
         if (val_p) check("valid_width", snes_valid, 0);
         if (snes_valid && !val_p) begin
            check("falls", falls, 16);
            check("valid_delay", cyc - rise_cyc, 137);
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) check("data", snes_data, sb.pop_front());
            nvalid++;
         end
      end
      lat_p = snes_latch;
      clk_p = snes_clock;
      val_p = snes_valid;
   end

   task automatic wait_valid();
      int n0 = nvalid;
      for (int i = 0; i < 400 && nvalid == n0; i++) @(posedge clk);
      check("valid_seen", nvalid != n0, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_latch"}, snes_latch, 0);
      check({tag, "_clock"}, snes_clock, 1);
      check({tag, "_data"}, snes_data, 0);
      check({tag, "_valid"}, snes_valid, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("rst");
      sb.push_back(12'h000);
      @(negedge clk);
      reset = 1;
      rel_cyc = cyc;
      after_rel = 1;
      repeat (190) @(posedge clk);
      #1 check("idle_busy", busy, 0);
      wait_valid();
      pat = 16'hFFF6;
      sb.push_back(12'h009);
      wait_valid();
      repeat (40) @(posedge clk);
      #1 check("hold_data", snes_data, 12'h009);
      check("hold_valid", snes_valid, 0);
      pat = 16'h00FF;
      sb.push_back(12'hF00);
      wait_valid();
      pat = 16'hFFEF;
      sb.push_back(12'h010);
      wait_valid();
      pat = 16'hFF7F;
      for (int i = 0; i < 400 && falls != 6; i++) @(posedge clk);
      check("reached_pulse5", falls, 6);
      #1 reset = 0;
      #1 check_reset_outputs("mid");
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1;
      rel_cyc = cyc;
      after_rel = 1;
      repeat (100) @(posedge clk);
      #1 check("post_rst_data", snes_data, 0);
      sb.push_back(12'h080);
      wait_valid();
      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/snes_reader.md
# snes_reader

Polls an SNES game pad over its three-wire serial interface and presents a debounced-by-frame, active-high 12-bit button word to the CPU controller's `snes_data[11:0]` input, which the SNES read instruction consumes. It is directly upstream of the control FSM. It generates the pad's latch and clock pulses at a fixed poll rate, shifts in 16 serial bits, and updates its output once per complete frame.

## Interface
Parameters:
- `TICK_DIV`, 300: half-period of `snes_clock` and of the latch pulse, in `clk` cycles (6 µs at 50 MHz). Minimum is 4.
- `POLL_DIV`, 833333: frame start period in `clk` cycles (60 Hz at 50 MHz). Must be greater than 34*`TICK_DIV` + 2.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `snes_serial_in` in 1: pad data line, asynchronous to `clk`. A pressed button reads 0.
- `snes_latch` out 1: pad latch, active high.
- `snes_clock` out 1: pad shift clock. Idles high.
- `snes_data` out 12: button word, 1 = pressed.
  - bit 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R.
- `snes_valid` out 1: one-cycle pulse when `snes_data` has just been updated.
- `busy` out 1: high while a frame is in progress.

## Operation
- Reset values: `snes_latch`=0, `snes_clock`=1, `snes_data`=0, `snes_valid`=0, `busy`=0. The state is IDLE and all counters are 0.
- `snes_serial_in` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- The poll counter is free-running from 0 to `POLL_DIV`-1 and wraps. A frame starts on the wrap. Because `POLL_DIV` exceeds the frame length, a wrap never occurs mid-frame.
- States:
  - IDLE: `busy`=0. On poll wrap, go to LATCH.
  - LATCH: `snes_latch`=1 for 2*`TICK_DIV` cycles, then go to CLK_LO with bit index 0.
  - CLK_LO: `snes_clock`=0 for `TICK_DIV` cycles. In the last cycle, sample the synchronized input into shift bit[index]. Then go to CLK_HI.
  - CLK_HI: `snes_clock`=1 for `TICK_DIV` cycles.
    - If index < 15: increment index and return to CLK_LO.
    - Otherwise go to DONE.
  - DONE: one cycle. `snes_data` ← inverted shift bits [11:0]. `snes_valid`=1. Go to IDLE.
- Shift bits 12–15 are sampled and then discarded.
- `snes_data` holds its value between frames. It changes only in DONE.
- With the pad absent, the line is pulled high, which reads as all released. `snes_data` then becomes 0.
- Reset asserted at any point, including mid-frame, aborts the frame immediately and forces the reset values. A partial shift is never published.

## Timing
- `busy` rises one cycle after the poll wrap. It falls the cycle after DONE.
- Latch high time is exactly 2*`TICK_DIV` cycles.
- There are exactly 16 falling edges of `snes_clock` per frame, with period 2*`TICK_DIV`.
- Frame length from latch rise to `snes_valid` is 34*`TICK_DIV` cycles. `snes_valid` is asserted in the following cycle.
- Bit 0 becomes valid at latch fall. It is sampled `TICK_DIV` cycles later, which exceeds the 2-cycle synchronizer latency.
- Bit i+1 is presented by the pad at the rising edge of pulse i and sampled at the end of the next low half.
- The first frame starts `POLL_DIV` cycles after reset deasserts. Frames are spaced exactly `POLL_DIV` cycles apart.
- Output latency is one `clk` cycle. `snes_valid` and the new `snes_data` appear in the same cycle.

## Structure
- Package `snes_pkg`:
  - button index constants `SNES_B`…`SNES_R` (0–11);
  - state encoding IDLE/LATCH/CLK_LO/CLK_HI/DONE;
  - `SNES_BITS`=16 and `SNES_BTNS`=12.
- Sub-module `sync2`: a 2-flop synchronizer with asynchronous active-low reset. It resets to 1, which reads as released.
- The rest of the block lives in the top module: the FSM, the tick counter, the poll counter, the 4-bit index, and the 16-bit shift register.

## Test plan
Bench parameters: `TICK_DIV`=4, `POLL_DIV`=200. The pad model shifts out a 16-bit pattern: bit 0 at latch fall, then each subsequent bit on the rising edge of `snes_clock`.
- Reset held low → `snes_latch`=0, `snes_clock`=1, `snes_data`=12'h000, `snes_valid`=0, `busy`=0. No activity before 200 cycles after release.
- Pad releases all buttons (line high throughout) → latch high for exactly 8 cycles, 16 clock falling edges, `snes_valid` one cycle, `snes_data`=12'h000.
- B and Start pressed (bits 0 and 3 low) → `snes_data`=12'h009. The value holds until the next `snes_valid`.
- A, X, L, R pressed, then next frame Up only → `snes_data`=12'hF00, then 12'h010. Bits 12–15 driven low do not affect the output.
- Frame cadence → latch rising edges exactly 200 cycles apart. `snes_valid` exactly 137 cycles after latch rise (34*4 + 1).
- Reset pulsed low during pulse 5 of a frame with Right pressed → outputs return to reset values at once and `snes_data` stays 12'h000. The next latch rises 200 cycles after release, and `snes_data`=12'h080 after that frame.
